// File: rtl/fetch_queue.sv
// Decoupled instruction fetch: credit-limited sequential request issue to instruction
// memory, in-order response capture into a show-ahead FIFO, redirect flush with stale drop.
module fetch_queue #(
    parameter int               DATAW     = 32,
    parameter logic [DATAW-1:0] BASE_ADDR = 32'h0100_0000,
    parameter int               DEPTH     = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             redirect,
    input  logic [DATAW-1:0] redirect_pc,
    output logic             imem_req_valid,
    output logic [DATAW-1:0] imem_req_addr,
    input  logic             imem_req_ready,
    input  logic             imem_rsp_valid,
    input  logic [DATAW-1:0] imem_rsp_data,
    output logic             out_valid,
    output logic [DATAW-1:0] out_pc,
    output logic [DATAW-1:0] out_instr,
    input  logic             out_ready
);

    localparam int               AW      = $clog2(DEPTH);
    localparam int               CW      = AW + 1;
    localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
    localparam logic [DATAW-1:0] PC_STEP = DATAW'(4);

    logic [DATAW-1:0] fetch_pc;
    logic [DATAW-1:0] rsp_pc;
    logic [CW-1:0]    count;
    logic [CW-1:0]    outstanding;
    logic [CW-1:0]    discard;
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [DATAW-1:0] pc_mem    [DEPTH];
    logic [DATAW-1:0] instr_mem [DEPTH];

    logic [CW:0]      committed;
    logic [CW-1:0]    outstanding_next;
    logic [DATAW-1:0] target;
    logic             req_fire;
    logic             rsp_write;
    logic             deq;
    logic             unused_low_bits;

    // Slots already promised: buffered entries plus responses that will still be kept.
    assign committed        = {1'b0, count} + {1'b0, outstanding} - {1'b0, discard};
    assign imem_req_valid   = reset && !redirect && (outstanding < DEPTH_C)
                              && (committed < {1'b0, DEPTH_C});
    assign imem_req_addr    = fetch_pc;
    assign req_fire         = imem_req_valid && imem_req_ready;
    assign rsp_write        = imem_rsp_valid && (discard == '0) && !redirect;
    assign out_valid        = (count != '0);
    assign deq              = out_valid && out_ready && !redirect;
    assign out_pc           = out_valid ? pc_mem[head]    : '0;
    assign out_instr        = out_valid ? instr_mem[head] : '0;
    assign outstanding_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
    assign target           = {redirect_pc[DATAW-1:2], 2'b00};
    assign unused_low_bits  = ^redirect_pc[1:0];

    always_ff @(posedge clock) begin
        if (!reset) begin
            fetch_pc    <= BASE_ADDR;
            rsp_pc      <= BASE_ADDR;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            head        <= '0;
            tail        <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect) begin
                // Everything still in flight belongs to the old path, including
                // any response that was not consumed this cycle.
                fetch_pc <= target;
                rsp_pc   <= target;
                count    <= '0;
                head     <= '0;
                tail     <= '0;
                discard  <= outstanding - CW'(imem_rsp_valid);
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                if (imem_rsp_valid && (discard != '0)) begin
                    discard <= discard - CW'(1);
                end
                if (rsp_write) begin
                    rsp_pc <= rsp_pc + PC_STEP;
                    tail   <= tail + AW'(1);
                end
                if (deq) begin
                    head <= head + AW'(1);
                end
                count <= count + CW'(rsp_write) - CW'(deq);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rsp_write) begin
            pc_mem[tail]    <= rsp_pc;
            instr_mem[tail] <= imem_rsp_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            assert (!(imem_rsp_valid && (outstanding == '0)))
                else $error("fetch_queue: response with no request outstanding");
            assert (!(rsp_write && (count == DEPTH_C)))
                else $error("fetch_queue: write into full buffer");
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a memory model queues expected {pc, instr} at each
// accepted request; a monitor pops and compares on every dequeue from the DUT.
module tb_fetch_queue;

    localparam logic [31:0] BASE = 32'h0100_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready = 1'b0;

    int tests = 0;
    int fails = 0;
    int cycle = 0;
    int lat = 1;
    bit mem_hold = 1'b0;
    int hs_count = 0;
    int hs_base = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_req_pc = BASE;
    bit          prev_wait = 1'b0;
    logic [31:0] prev_addr = '0;

    fetch_queue #(.DATAW(32), .BASE_ADDR(BASE), .DEPTH(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_ready      (out_ready)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cycle <= cycle + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        redirect = 1'b0;
        mem_hold = 1'b0;
        imem_req_ready = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic wait_out(input string name, input logic [31:0] exp_pc, input int max_cycles);
        int n;
        n = 0;
        while (!out_valid && n < max_cycles) begin
            @(negedge clock);
            n++;
        end
        if (!out_valid) begin
            tests++;
            fails++;
            $display("FAIL %s: out_valid never rose within %0d cycles, expected pc %h", name, max_cycles, exp_pc);
        end else begin
            check(name, out_pc, exp_pc);
        end
    endtask

    // Memory model: in-order responses after lat cycles, request address/stability checks.
    always @(negedge clock) begin
        if (!reset) begin
            pend.delete();
            exp_q.delete();
            exp_req_pc = BASE;
            imem_rsp_valid = 1'b0;
            imem_rsp_data = '0;
            prev_wait = 1'b0;
        end else begin
            if (!mem_hold && pend.size() > 0 && pend[0].due <= cycle) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data = mem_word(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data = '0;
            end
            if (redirect) begin
                check_bit("redirect_req_valid", imem_req_valid, 1'b0);
                exp_q.delete();
                exp_req_pc = {redirect_pc[31:2], 2'b00};
            end else begin
                if (prev_wait) begin
                    check_bit("hold_valid", imem_req_valid, 1'b1);
                    check("hold_addr", imem_req_addr, prev_addr);
                end
                if (imem_req_valid && imem_req_ready) begin
                    check("req_addr", imem_req_addr, exp_req_pc);
                    pend.push_back('{imem_req_addr, cycle + lat});
                    exp_q.push_back(exp_req_pc);
                    exp_req_pc = exp_req_pc + 32'd4;
                    hs_count++;
                end
            end
            prev_wait = imem_req_valid && !imem_req_ready && !redirect;
            prev_addr = imem_req_addr;
        end
    end

    // Monitor: every dequeue must match the oldest expected entry.
    always @(negedge clock) begin : monitor
        logic [31:0] e;
        if (reset && !redirect && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_empty: dequeued pc %h, required no entry", out_pc);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", out_pc, e);
                check("sb_instr", out_instr, mem_word(e));
            end
        end
    end

    initial begin
        // Cold start and reset state.
        reset = 1'b0;
        tick();
        sample();
        check_bit("rst_out_valid", out_valid, 1'b0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        check_bit("rst_req_valid", imem_req_valid, 1'b0);
        tick();
        reset = 1'b1; lat = 1; imem_req_ready = 1'b1; out_ready = 1'b1;
        sample();
        check_bit("t1_req_valid", imem_req_valid, 1'b1);
        check("t1_addr0", imem_req_addr, 32'h0100_0000);
        check_bit("t1_out_valid_c0", out_valid, 1'b0);
        tick(); sample();
        check("t1_addr1", imem_req_addr, 32'h0100_0004);
        check_bit("t1_out_valid_c1", out_valid, 1'b0);
        tick(); sample();
        check_bit("t1_out_valid_c2", out_valid, 1'b1);
        check("t1_out_pc", out_pc, 32'h0100_0000);
        repeat (8) tick();

        // Decode stall fills the buffer, then drains in order.
        do_reset();
        reset = 1'b1; lat = 1; imem_req_ready = 1'b1; out_ready = 1'b0;
        hs_base = hs_count;
        repeat (10) tick();
        sample();
        check_bit("t2_req_valid_full", imem_req_valid, 1'b0);
        check_bit("t2_out_valid", out_valid, 1'b1);
        check("t2_out_pc_head", out_pc, 32'h0100_0000);
        check("t2_req_count", 32'(hs_count - hs_base), 32'd4);
        tick();
        out_ready = 1'b1;
        sample();
        check_bit("t2_req_valid_release", imem_req_valid, 1'b0);
        tick(); sample();
        check_bit("t2_resume_valid", imem_req_valid, 1'b1);
        check("t2_resume_addr", imem_req_addr, 32'h0100_0010);
        check("t2_second_pc", out_pc, 32'h0100_0004);
        repeat (8) tick();

        // Redirect with two requests outstanding.
        do_reset();
        reset = 1'b1; lat = 1; imem_req_ready = 1'b1; out_ready = 1'b1; mem_hold = 1'b1;
        tick();
        tick();
        imem_req_ready = 1'b0;
        sample();
        check("t3_third_addr", imem_req_addr, 32'h0100_0008);
        tick();
        redirect = 1'b1; redirect_pc = 32'h0100_0103; imem_req_ready = 1'b1;
        sample();
        tick();
        redirect = 1'b0; mem_hold = 1'b0;
        sample();
        check_bit("t3_req_valid", imem_req_valid, 1'b1);
        check("t3_req_addr", imem_req_addr, 32'h0100_0100);
        wait_out("t3_first_pc", 32'h0100_0100, 20);
        repeat (6) tick();

        // Redirect coinciding with a response and a dequeue.
        do_reset();
        reset = 1'b1; lat = 2; imem_req_ready = 1'b1; out_ready = 1'b0;
        repeat (4) tick();
        redirect = 1'b1; redirect_pc = 32'h0200_0000; out_ready = 1'b1;
        sample();
        check_bit("t4_head_valid", out_valid, 1'b1);
        check("t4_head_pc", out_pc, 32'h0100_0000);
        tick();
        redirect = 1'b0;
        sample();
        check_bit("t4_flushed", out_valid, 1'b0);
        check_bit("t4_req_valid", imem_req_valid, 1'b1);
        check("t4_req_addr", imem_req_addr, 32'h0200_0000);
        wait_out("t4_first_pc", 32'h0200_0000, 20);
        repeat (6) tick();

        // Request ready toggling every cycle.
        do_reset();
        reset = 1'b1; lat = 1; out_ready = 1'b1;
        hs_base = hs_count;
        for (int i = 0; i < 16; i++) begin
            imem_req_ready = i[0];
            tick();
        end
        imem_req_ready = 1'b0;
        repeat (4) tick();
        sample();
        check("t5_req_count", 32'(hs_count - hs_base), 32'd8);
        check("t5_drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-stream with three entries buffered.
        do_reset();
        reset = 1'b1; lat = 1; imem_req_ready = 1'b1; out_ready = 1'b0;
        repeat (3) tick();
        sample();
        check_bit("t6_pre_valid", out_valid, 1'b1);
        tick();
        reset = 1'b0;
        tick();
        sample();
        check_bit("t6_out_valid", out_valid, 1'b0);
        check("t6_out_pc", out_pc, 32'h0);
        check_bit("t6_req_valid", imem_req_valid, 1'b0);
        tick();
        reset = 1'b1; out_ready = 1'b1;
        sample();
        check_bit("t6_restart_valid", imem_req_valid, 1'b1);
        check("t6_restart_addr", imem_req_addr, 32'h0100_0000);
        repeat (6) tick();
        imem_req_ready = 1'b0;
        repeat (6) tick();
        sample();
        check("final_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupled instruction-fetch stage; sits directly upstream of the FD pipeline register and decoder.
- Generates sequential fetch addresses and issues them to instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned {pc, instr} pairs in a small FIFO. Decode stalls become backpressure rather than PC holds.
- A taken branch or jump redirects fetch, flushes the buffer and drops stale in-flight responses.

Parameters:
- DATAW, 32: address and instruction width.
- BASE_ADDR, 32'h01000000: fetch PC after reset.
- DEPTH, 4: FIFO entries, and the maximum number of outstanding requests (power of 2, ≥2).

Ports:
- clock  input  1  single clock; all state changes on posedge.
- reset  input  1  synchronous, active-low (0 = reset).
- redirect  input  1  taken branch/jump from execute; flush and refetch.
- redirect_pc  input  DATAW  new fetch PC; bits [1:0] are ignored and treated as 0.
- imem_req_valid  output  1  request valid.
- imem_req_addr  output  DATAW  request word address.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_rsp_valid  input  1  response valid; responses return in request order.
- imem_rsp_data  input  DATAW  instruction word.
- out_valid  output  1  head entry valid.
- out_pc  output  DATAW  head entry PC.
- out_instr  output  DATAW  head entry instruction.
- out_ready  input  1  decode consumes the head; driven low on a decode stall.

Behaviour:
Reset (reset==0 at posedge):
- fetch_pc = BASE_ADDR; rsp_pc = BASE_ADDR.
- FIFO count = 0; outstanding = 0; discard = 0.
- Consequently out_valid=0, out_pc=0, out_instr=0, imem_req_valid=0 in the first cycle after reset.
- Applies mid-operation: in-flight responses arriving after reset are NOT discarded. The memory must be reset together with this block.

Request issue:
- imem_req_valid = !redirect && (outstanding < DEPTH) && (count + outstanding − discard < DEPTH).
- imem_req_addr = fetch_pc.
- On handshake (valid && ready): fetch_pc += 4; outstanding += 1.
- Once asserted, valid stays asserted and the address stays stable until ready, unless redirect occurs.

Response:
- Every imem_rsp_valid cycle decrements outstanding. More responses than outstanding is illegal; assert in simulation.
- If discard>0: response dropped; discard −= 1.
- Otherwise: {rsp_pc, imem_rsp_data} is written at the tail; rsp_pc += 4.
- The credit rule guarantees the FIFO never overflows. Write-when-full is an assertion failure.

Output:
- Show-ahead FIFO: out_valid = (count != 0). out_pc/out_instr are the head entry; both are 0 when empty.
- Dequeue on out_valid && out_ready. Enqueue and dequeue in the same cycle leave count unchanged.
- Latency: address issued in cycle N, response in cycle N+k, entry visible on out_* at N+k+1 (no bypass).

Redirect (priority over everything else in its cycle):
- FIFO cleared (count=0); any dequeue in that cycle is ignored.
- fetch_pc = rsp_pc = {redirect_pc[DATAW−1:2], 2'b00}.
- No request issued in the redirect cycle (imem_req_valid=0).
- A response arriving in the redirect cycle is dropped.
- discard = discard_next = outstanding − (imem_rsp_valid ? 1 : 0). All previously in-flight responses are dropped.
- Back-to-back redirects: each reloads the PCs and recomputes discard from the current outstanding count. Only the last target is fetched.

Arithmetic:
- PC adds wrap modulo 2^DATAW.
- count, outstanding and discard are $clog2(DEPTH)+1 bits wide.
- Underflow of any counter is an assertion failure.

Test Plan:
1. Cold start, imem_req_ready=1, 1-cycle response, out_ready=1 → requests 0x01000000, 0x01000004, …; first out_valid two cycles after the first request, with out_pc=0x01000000.
2. out_ready=0 for 10 cycles with DEPTH=4 → exactly 4 requests issued, count=4, imem_req_valid=0. Release out_ready → entries drained in PC order, issue resumes at 0x01000010.
3. Two requests outstanding, redirect=1 with redirect_pc=0x01000103 → next request address 0x01000100; both stale responses dropped; first out_pc=0x01000100.
4. Redirect in the same cycle as imem_rsp_valid and out_ready → that response is dropped, the head is not consumed, FIFO is empty next cycle, and discard = outstanding−1.
5. imem_req_ready toggling 0/1 every cycle → imem_req_addr is held stable while ready=0; no duplicate or skipped PCs.
6. reset=0 asserted mid-stream with count=3 → the next cycle shows out_valid=0, and the first request after release is 0x01000000.
